// File: rtl/mem_copier.sv
// -----------------------------------------------------------------------------
// mem_copier
//
// Block-transfer engine that drives the memory get/set port. It copies `len`
// bytes from `src` to `dst`, or fills `len` bytes starting at `dst` with the
// byte given on `src`. The engine owns the memory port while `busy` is high.
//
// Ports
//   clk       in   system clock, all state changes on the rising edge
//   reset     in   synchronous active-high reset
//   start     in   transfer request, only honoured in IDLE
//   fill      in   mode sampled with start: 0 = copy, 1 = fill
//   src [7:0] in   copy source base address, or fill byte
//   dst [7:0] in   destination base address
//   len [7:0] in   byte count, 0 means no transfer
//   busy      out  high while reading/writing
//   done      out  one-cycle completion pulse
//   mem_addr  out  memory address
//   mem_val   out  memory write data
//   mem_get   out  memory read strobe (data appears on mem_out next cycle)
//   mem_set   out  memory write strobe
//   mem_out   in   memory read data, held by the memory while get is low
// -----------------------------------------------------------------------------
module mem_copier (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       fill,
    input  logic [7:0] src,
    input  logic [7:0] dst,
    input  logic [7:0] len,
    output logic       busy,
    output logic       done,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_val,
    output logic       mem_get,
    output logic       mem_set,
    input  logic [7:0] mem_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0] state_r;
    logic       mode_r;     // 1 = fill, 0 = copy
    logic [7:0] sbase_r;    // source base, or fill byte in fill mode
    logic [7:0] dbase_r;
    logic [7:0] cnt_r;
    logic [7:0] idx_r;

    logic [7:0] idx_inc_s;
    logic       last_s;

    // Index of the byte after the one being written; the transfer ends when
    // it reaches the latched count. cnt_r is at least 1 whenever WR is live,
    // so len=255 terminates at idx=254 without any wrap of idx itself.
    assign idx_inc_s = idx_r + 8'd1;
    assign last_s    = (idx_inc_s == cnt_r);

    // Transfer sequencer: command latch, state progression and byte index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            mode_r  <= 1'b0;
            sbase_r <= 8'h00;
            dbase_r <= 8'h00;
            cnt_r   <= 8'h00;
            idx_r   <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mode_r  <= fill;
                        sbase_r <= src;
                        dbase_r <= dst;
                        cnt_r   <= len;
                        idx_r   <= 8'h00;
                        if (len == 8'h00) begin
                            state_r <= ST_DONE;
                        end else if (fill) begin
                            state_r <= ST_WR;
                        end else begin
                            state_r <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    state_r <= ST_WR;
                end
                ST_WR: begin
                    idx_r <= idx_inc_s;
                    if (last_s) begin
                        state_r <= ST_DONE;
                    end else if (mode_r) begin
                        state_r <= ST_WR;
                    end else begin
                        state_r <= ST_RD;
                    end
                end
                ST_DONE: begin
                    // A start seen here is deliberately dropped.
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from the registered state. The only input feeding an
    // output is mem_out, which is forwarded as write data in copy WR: the
    // byte fetched in the preceding RD is held by the memory for this cycle.
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        mem_get  = 1'b0;
        mem_set  = 1'b0;
        mem_addr = 8'h00;
        mem_val  = 8'h00;
        case (state_r)
            ST_RD: begin
                busy     = 1'b1;
                mem_get  = 1'b1;
                mem_addr = sbase_r + idx_r;
            end
            ST_WR: begin
                busy     = 1'b1;
                mem_set  = 1'b1;
                mem_addr = dbase_r + idx_r;
                mem_val  = mode_r ? sbase_r : mem_out;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copier.sv
// -----------------------------------------------------------------------------
// tb_mem_copier
//
// Self-checking bench for mem_copier. A 256x8 memory with one-cycle read
// latency is attached to the DUT port. A transfer-level model computes, for
// each accepted command, the expected per-cycle port activity and the
// resulting memory image by walking the bytes in ascending order. One compare
// process checks every cycle's outputs against that expectation; directed
// literal checks pin completion cycles and destination bytes.
// -----------------------------------------------------------------------------
module tb_mem_copier;

    logic       clk;
    logic       reset;
    logic       start;
    logic       fill;
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] len;
    logic       busy;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_val;
    logic       mem_get;
    logic       mem_set;
    logic [7:0] mem_out;

    mem_copier dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .fill     (fill),
        .src      (src),
        .dst      (dst),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .mem_addr (mem_addr),
        .mem_val  (mem_val),
        .mem_get  (mem_get),
        .mem_set  (mem_set),
        .mem_out  (mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic cmp_on = 1'b0;

    // Memory attached to the DUT, plus a back-door poke path used for preload.
    logic [7:0] mem [256];
    logic       poke_en   = 1'b0;
    logic [7:0] poke_addr = 8'h00;
    logic [7:0] poke_data = 8'h00;

    always @(posedge clk) begin
        if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else begin
            if (mem_get) mem_out <= mem[mem_addr];
            if (mem_set) mem[mem_addr] <= mem_val;
        end
    end

    // Model state: expected memory image and expected per-cycle outputs.
    // Record layout: {busy, done, get, set, addr[7:0], val[7:0]}.
    logic [7:0]  model_mem [256];
    logic [19:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transfer model: bytes processed in ascending order, each copy byte read
    // from the model image as it stands at that moment, then written. Only
    // cycles up to 'limit' (relative to the start cycle) are recorded/applied.
    task automatic model_xfer(input logic f, input logic [7:0] s, input logic [7:0] d,
                              input logic [7:0] n, input int limit);
        int         cyc;
        logic [7:0] off;
        logic [7:0] ra;
        logic [7:0] wa;
        logic [7:0] v;
        exp_q.push_back(20'h00000);
        cyc = 1;
        for (int i = 0; i < int'(n); i++) begin
            off = i[7:0];
            ra  = s + off;
            wa  = d + off;
            if (!f) begin
                if (cyc <= limit) exp_q.push_back({4'b1010, ra, 8'h00});
                cyc++;
                v = model_mem[ra];
            end else begin
                v = s;
            end
            if (cyc <= limit) begin
                exp_q.push_back({4'b1001, wa, v});
                model_mem[wa] = v;
            end
            cyc++;
        end
        if (cyc <= limit) exp_q.push_back({4'b0100, 16'h0000});
    endtask

    // Per-cycle output comparison against the model.
    always @(negedge clk) begin
        logic [19:0] e;
        if (cmp_on) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 20'h00000;
            chk("port_outputs", {busy, done, mem_get, mem_set, mem_addr, mem_val}, e);
        end
    end

    // All tasks below start and end 1 time unit after a rising edge.
    task automatic poke(input logic [7:0] a, input logic [7:0] v);
        poke_en      = 1'b1;
        poke_addr    = a;
        poke_data    = v;
        model_mem[a] = v;
        @(posedge clk);
        #1;
        poke_en = 1'b0;
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 256; a++) poke(a[7:0], 8'h00);
    endtask

    task automatic mem_cmp(input string name);
        int bad;
        bad = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== model_mem[a]) bad++;
        chk(name, bad, 0);
    endtask

    // Issue a command, optionally hammer start/len while it runs, and measure
    // the cycle (relative to the start cycle) in which done is seen.
    task automatic do_xfer(input logic f, input logic [7:0] s, input logic [7:0] d,
                           input logic [7:0] n, input logic junk, input int exp_cyc);
        int k;
        logic [31:0] r;
        fill  = f;
        src   = s;
        dst   = d;
        len   = n;
        start = 1'b1;
        model_xfer(f, s, d, n, 100000);
        k = 0;
        while (k < 600) begin
            @(negedge clk);
            if (done) break;
            if (k == 1) start = 1'b0;
            if (junk && (k == 2 || k == 3)) begin
                r     = $urandom;
                start = 1'b1;
                fill  = r[0];
                src   = r[15:8];
                dst   = r[23:16];
                len   = r[31:24] | 8'h01;
            end
            if (junk && k == 4) start = 1'b0;
            k++;
        end
        start = 1'b0;
        chk("done_cycle", k, exp_cyc);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        fill  = 1'b0;
        src   = 8'h00;
        dst   = 8'h00;
        len   = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {busy, done, mem_get, mem_set, mem_addr, mem_val}, 20'h00000);
        cmp_on = 1'b1;
        reset  = 1'b0;
        clear_mem();

        // Basic copy.
        poke(8'h10, 8'hAA);
        poke(8'h11, 8'hBB);
        poke(8'h12, 8'hCC);
        poke(8'h13, 8'hDD);
        do_xfer(1'b0, 8'h10, 8'h80, 8'd4, 1'b0, 9);
        chk("copy_80", mem[8'h80], 8'hAA);
        chk("copy_81", mem[8'h81], 8'hBB);
        chk("copy_82", mem[8'h82], 8'hCC);
        chk("copy_83", mem[8'h83], 8'hDD);
        chk("model_copy_83", model_mem[8'h83], 8'hDD);
        mem_cmp("copy_image");

        // Fill wrapping past 0xFF.
        do_xfer(1'b1, 8'h5A, 8'hFE, 8'd3, 1'b0, 4);
        chk("fill_fe", mem[8'hFE], 8'h5A);
        chk("fill_ff", mem[8'hFF], 8'h5A);
        chk("fill_00", mem[8'h00], 8'h5A);
        mem_cmp("fill_image");

        // Overlapping forward copy.
        clear_mem();
        poke(8'h20, 8'h11);
        poke(8'h21, 8'h22);
        do_xfer(1'b0, 8'h20, 8'h22, 8'd4, 1'b0, 9);
        chk("ovl_22", mem[8'h22], 8'h11);
        chk("ovl_23", mem[8'h23], 8'h22);
        chk("ovl_24", mem[8'h24], 8'h11);
        chk("ovl_25", mem[8'h25], 8'h22);
        chk("model_ovl_25", model_mem[8'h25], 8'h22);
        mem_cmp("ovl_image");

        // Zero length.
        do_xfer(1'b0, 8'h20, 8'h90, 8'd0, 1'b0, 1);
        mem_cmp("zero_image");

        // Copy with start/len/mode/address churn while running.
        poke(8'h10, 8'hAA);
        poke(8'h11, 8'hBB);
        poke(8'h12, 8'hCC);
        poke(8'h13, 8'hDD);
        do_xfer(1'b0, 8'h10, 8'h40, 8'd4, 1'b1, 9);
        chk("junk_40", mem[8'h40], 8'hAA);
        chk("junk_43", mem[8'h43], 8'hDD);
        mem_cmp("junk_image");

        // Reset in cycle 6 of an 8-byte copy.
        fill  = 1'b0;
        src   = 8'h10;
        dst   = 8'h60;
        len   = 8'd8;
        start = 1'b1;
        model_xfer(1'b0, 8'h10, 8'h60, 8'd8, 6);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) start = 1'b0;
            if (c == 6) reset = 1'b1;
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_mid_outputs", {busy, done, mem_get, mem_set, mem_addr, mem_val}, 20'h00000);
        chk("rst_mid_60", mem[8'h60], 8'hAA);
        chk("rst_mid_62", mem[8'h62], 8'hCC);
        chk("rst_mid_63", mem[8'h63], 8'h00);
        mem_cmp("rst_mid_image");
        do_xfer(1'b1, 8'h77, 8'h63, 8'd1, 1'b0, 2);
        chk("fresh_63", mem[8'h63], 8'h77);

        // Full-length overlapping copy with wrapping destination.
        for (int a = 0; a < 256; a++) poke(a[7:0], a[7:0] ^ 8'h5A);
        do_xfer(1'b0, 8'h01, 8'h80, 8'd255, 1'b0, 511);
        chk("full_80", mem[8'h80], 8'h5B);
        chk("full_00", mem[8'h00], 8'h58);
        chk("full_7e", mem[8'h7E], 8'h5B);
        chk("model_full_7e", model_mem[8'h7E], 8'h5B);
        mem_cmp("full_image");

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
